// File: rtl/mbist_mem_pkg.sv
// Shared types and elaboration helpers for the MBIST single-port target RAM.
// Optional stuck-at fault injection is enabled by defining MBIST_FAULT_INJ_EN.
package mbist_mem_pkg;

    // Controller state: CLEAR zeroes the array after reset, READY serves traffic.
    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    // Legal read-latency range, checked at elaboration by the top.
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    // NBYTES helper: number of byte lanes in a word of the given width.
    function automatic int unsigned nbytes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // DEPTH helper: number of words addressable with the given address width.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/mbist_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of valid + data with asynchronous reset.
// The last stage drives dout/rvalid; data stages only advance on a valid entry,
// so dout holds the most recent read value while rvalid is low.
module mbist_rd_pipe #(
    parameter int unsigned DATA   = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rd_i,
    input  logic [DATA-1:0] rdata_i,
    output logic            rvalid_o,
    output logic [DATA-1:0] dout_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [DATA-1:0]   data_q [RD_LAT];

    // Shift read strobes and sampled words toward the output stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= rd_i;
            if (rd_i) begin
                data_q[0] <= rdata_i;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign rvalid_o = valid_q[RD_LAT-1];
    assign dout_o   = data_q[RD_LAT-1];

endmodule

// File: rtl/mbist_mem_sp.sv
// MBIST target single-port RAM: byte-write enables, pipelined reads with a
// valid strobe, a write/read conflict flag and a post-reset clear sequencer.
// Define MBIST_FAULT_INJ_EN to add fi_* ports that force one bit of reads
// from a chosen address, modelling a stuck-at cell.
module mbist_mem_sp
    import mbist_mem_pkg::*;
#(
    parameter int unsigned ADDR   = 4,
    parameter int unsigned DATA   = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic                     ren,
    input  logic [DATA/8-1:0]        be,
    input  logic [ADDR-1:0]          address,
    input  logic [DATA-1:0]          din,
    output logic [DATA-1:0]          dout,
    output logic                     rvalid,
    output logic                     busy,
    output logic                     conflict
`ifdef MBIST_FAULT_INJ_EN
    ,
    input  logic                     fi_en,
    input  logic [ADDR-1:0]          fi_addr,
    input  logic [$clog2(DATA)-1:0]  fi_bit,
    input  logic                     fi_val
`endif
);

    localparam int unsigned NBYTES = nbytes_of(DATA);
    localparam int unsigned DEPTH  = depth_of(ADDR);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mbist_mem_sp: RD_LAT must be within 1..3");
    end
    if ((DATA % 8) != 0) begin : g_bad_data
        $error("mbist_mem_sp: DATA must be a multiple of 8");
    end

    state_e            state_q, state_d;
    logic [ADDR-1:0]   cnt_q, cnt_d;
    logic              conflict_q, conflict_d;
    logic              clr_we;
    logic              wr_en;
    logic              rd_en;
    logic [DATA-1:0]   rd_word;
    logic [DATA-1:0]   mem_q [DEPTH];

    // State, clear counter and conflict flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    // Sequence the clear sweep, then decode requests; wen/ren are ignored while clearing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = 1'b0;
        clr_we     = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == ADDR'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                wr_en      = wen & ~ren;
                rd_en      = ren & ~wen;
                conflict_d = wen & ren;
            end
            default: state_d = CLEAR;
        endcase
    end

    // Array update: clear sweep has priority, otherwise per-byte writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem_q[address][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // Word presented to the read pipeline, optionally with one bit forced.
    always_comb begin
        rd_word = mem_q[address];
`ifdef MBIST_FAULT_INJ_EN
        if (fi_en && (fi_addr == address)) begin
            rd_word[fi_bit] = fi_val;
        end
`endif
    end

    mbist_rd_pipe #(
        .DATA   (DATA),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i    (clk),
        .rst_i    (rst),
        .rd_i     (rd_en),
        .rdata_i  (rd_word),
        .rvalid_o (rvalid),
        .dout_o   (dout)
    );

    assign busy     = (state_q == CLEAR);
    assign conflict = conflict_q;

endmodule

// File: tb/tb_mbist_mem_sp.sv
// Directed bench for mbist_mem_sp (ADDR=4, DATA=16, RD_LAT=2 by default).
// Define MBIST_FAULT_INJ_EN to also exercise the stuck-at fault ports.
module tb_mbist_mem_sp;

    localparam int unsigned ADDR   = 4;
    localparam int unsigned DATA   = 16;
    localparam int unsigned RD_LAT = 2;
    localparam int          DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [3:0]  address = 4'd0;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        rvalid;
    logic        busy;
    logic        conflict;
`ifdef MBIST_FAULT_INJ_EN
    logic        fi_en = 1'b0;
    logic [3:0]  fi_addr = 4'd0;
    logic [3:0]  fi_bit = 4'd0;
    logic        fi_val = 1'b0;
`endif

    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;
    int          conf_cnt = 0;
    logic [15:0] rd_data_q [$];
    int          rd_cyc_q [$];

    mbist_mem_sp #(
        .ADDR   (ADDR),
        .DATA   (DATA),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .ren      (ren),
        .be       (be),
        .address  (address),
        .din      (din),
        .dout     (dout),
        .rvalid   (rvalid),
        .busy     (busy),
        .conflict (conflict)
`ifdef MBIST_FAULT_INJ_EN
        ,
        .fi_en    (fi_en),
        .fi_addr  (fi_addr),
        .fi_bit   (fi_bit),
        .fi_val   (fi_val)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture completed reads and conflict pulses away from the active edge.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            rd_data_q.push_back(dout);
            rd_cyc_q.push_back(cyc);
        end
        if (conflict === 1'b1) conf_cnt++;
    end

    task automatic drive(input logic w, input logic r, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] b);
        @(negedge clk);
        wen = w; ren = r; address = a; din = d; be = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        wen = 1'b1; ren = 1'b1; address = 4'd5; din = 16'hFFFF; be = 2'b11;
        repeat (3) @(negedge clk);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rst_busy: got %b, expected 1", busy); end
        vecs++; if (rvalid !== 1'b0) begin errs++; $display("FAIL rst_rvalid: got %b, expected 0", rvalid); end
        vecs++; if (conflict !== 1'b0) begin errs++; $display("FAIL rst_conflict: got %b, expected 0", conflict); end
        vecs++; if (dout !== 16'h0000) begin errs++; $display("FAIL rst_dout: got %h, expected 0000", dout); end
        rd_data_q.delete(); rd_cyc_q.delete(); conf_cnt = 0;
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            n++;
            if (busy === 1'b0) break;
        end
        wen = 1'b0; ren = 1'b0;
        vecs++; if (n !== DEPTH) begin errs++; $display("FAIL busy_cycles: got %0d, expected %0d", n, DEPTH); end
        idle(3);
        vecs++; if (rd_data_q.size() !== 0) begin errs++; $display("FAIL clear_rvalid: got %0d reads, expected 0", rd_data_q.size()); end
        vecs++; if (conf_cnt !== 0) begin errs++; $display("FAIL clear_conflict: got %0d, expected 0", conf_cnt); end
    endtask

    task automatic test_clear_readback();
        int c0;
        rd_data_q.delete(); rd_cyc_q.delete();
        c0 = 0;
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 1'b1, 4'(a), 16'h0000, 2'b00);
            if (a == 0) c0 = cyc;
        end
        idle(RD_LAT + 2);
        vecs++; if (rd_data_q.size() !== DEPTH) begin errs++; $display("FAIL clear_reads: got %0d, expected %0d", rd_data_q.size(), DEPTH); end
        for (int i = 0; i < rd_data_q.size(); i++) begin
            vecs++; if (rd_data_q[i] !== 16'h0000) begin errs++; $display("FAIL clear_data[%0d]: got %h, expected 0000", i, rd_data_q[i]); end
            vecs++; if (rd_cyc_q[i] !== c0 + RD_LAT + i) begin errs++; $display("FAIL clear_cycle[%0d]: got %0d, expected %0d", i, rd_cyc_q[i], c0 + RD_LAT + i); end
        end
    endtask

    task automatic test_byte_write();
        int c0;
        rd_data_q.delete(); rd_cyc_q.delete();
        drive(1'b1, 1'b0, 4'd3, 16'hA55A, 2'b11);
        drive(1'b1, 1'b0, 4'd3, 16'h1234, 2'b01);
        drive(1'b0, 1'b1, 4'd3, 16'h0000, 2'b00);
        c0 = cyc;
        idle(RD_LAT + 2);
        vecs++;
        if (rd_data_q.size() !== 1) begin
            errs++; $display("FAIL bw_reads: got %0d, expected 1", rd_data_q.size());
        end else begin
            vecs++; if (rd_data_q[0] !== 16'hA534) begin errs++; $display("FAIL bw_data: got %h, expected a534", rd_data_q[0]); end
            vecs++; if (rd_cyc_q[0] !== c0 + RD_LAT) begin errs++; $display("FAIL bw_latency: got %0d, expected %0d", rd_cyc_q[0], c0 + RD_LAT); end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'(i), 16'(16'h1111 * i), 2'b11);
        idle(1);
        rd_data_q.delete(); rd_cyc_q.delete();
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 4'(i), 16'h0000, 2'b00);
            if (i == 0) c0 = cyc;
        end
        idle(RD_LAT + 2);
        vecs++; if (rd_data_q.size() !== 4) begin errs++; $display("FAIL b2b_reads: got %0d, expected 4", rd_data_q.size()); end
        for (int i = 0; i < rd_data_q.size(); i++) begin
            vecs++; if (rd_data_q[i] !== 16'(16'h1111 * i)) begin errs++; $display("FAIL b2b_data[%0d]: got %h, expected %h", i, rd_data_q[i], 16'(16'h1111 * i)); end
            vecs++; if (rd_cyc_q[i] !== c0 + RD_LAT + i) begin errs++; $display("FAIL b2b_cycle[%0d]: got %0d, expected %0d", i, rd_cyc_q[i], c0 + RD_LAT + i); end
        end
        vecs++; if (dout !== 16'h3333) begin errs++; $display("FAIL dout_hold: got %h, expected 3333", dout); end
        vecs++; if (rvalid !== 1'b0) begin errs++; $display("FAIL rvalid_idle: got %b, expected 0", rvalid); end
    endtask

    task automatic test_conflict();
        drive(1'b1, 1'b0, 4'd5, 16'hBEEF, 2'b11);
        idle(1);
        rd_data_q.delete(); rd_cyc_q.delete(); conf_cnt = 0;
        drive(1'b1, 1'b1, 4'd5, 16'h0000, 2'b11);
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
        #1;
        vecs++; if (conflict !== 1'b1) begin errs++; $display("FAIL conflict_pulse: got %b, expected 1", conflict); end
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
        #1;
        vecs++; if (conflict !== 1'b0) begin errs++; $display("FAIL conflict_clear: got %b, expected 0", conflict); end
        idle(2);
        vecs++; if (conf_cnt !== 1) begin errs++; $display("FAIL conflict_count: got %0d, expected 1", conf_cnt); end
        vecs++; if (rd_data_q.size() !== 0) begin errs++; $display("FAIL conflict_rvalid: got %0d reads, expected 0", rd_data_q.size()); end
        drive(1'b0, 1'b1, 4'd5, 16'h0000, 2'b00);
        idle(RD_LAT + 2);
        vecs++;
        if (rd_data_q.size() !== 1) begin
            errs++; $display("FAIL conflict_readback_n: got %0d, expected 1", rd_data_q.size());
        end else begin
            vecs++; if (rd_data_q[0] !== 16'hBEEF) begin errs++; $display("FAIL conflict_readback: got %h, expected beef", rd_data_q[0]); end
        end
    endtask

    task automatic test_inflight();
        rd_data_q.delete(); rd_cyc_q.delete();
        drive(1'b1, 1'b0, 4'd7, 16'h0777, 2'b11);
        drive(1'b0, 1'b1, 4'd7, 16'h0000, 2'b00);
        drive(1'b1, 1'b0, 4'd7, 16'hFFFF, 2'b11);
        drive(1'b0, 1'b1, 4'd7, 16'h0000, 2'b00);
        idle(RD_LAT + 2);
        vecs++;
        if (rd_data_q.size() !== 2) begin
            errs++; $display("FAIL inflight_reads: got %0d, expected 2", rd_data_q.size());
        end else begin
            vecs++; if (rd_data_q[0] !== 16'h0777) begin errs++; $display("FAIL inflight_old: got %h, expected 0777", rd_data_q[0]); end
            vecs++; if (rd_data_q[1] !== 16'hFFFF) begin errs++; $display("FAIL inflight_new: got %h, expected ffff", rd_data_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        rd_data_q.delete(); rd_cyc_q.delete();
        drive(1'b0, 1'b1, 4'd3, 16'h0000, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1; ren = 1'b0;
        #1;
        vecs++; if (rvalid !== 1'b0) begin errs++; $display("FAIL midrst_rvalid: got %b, expected 0", rvalid); end
        vecs++; if (dout !== 16'h0000) begin errs++; $display("FAIL midrst_dout: got %h, expected 0000", dout); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL midrst_busy: got %b, expected 1", busy); end
        @(negedge clk); rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_at_cnt7: got %b, expected 1", busy); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            n++;
            if (busy === 1'b0) break;
        end
        vecs++; if (n !== DEPTH) begin errs++; $display("FAIL restart_busy_cycles: got %0d, expected %0d", n, DEPTH); end
        idle(RD_LAT + 2);
        vecs++; if (rd_data_q.size() !== 0) begin errs++; $display("FAIL inflight_dropped: got %0d reads, expected 0", rd_data_q.size()); end
        rd_data_q.delete(); rd_cyc_q.delete();
        drive(1'b0, 1'b1, 4'd3, 16'h0000, 2'b00);
        idle(RD_LAT + 2);
        vecs++;
        if (rd_data_q.size() !== 1) begin
            errs++; $display("FAIL recleared_reads: got %0d, expected 1", rd_data_q.size());
        end else begin
            vecs++; if (rd_data_q[0] !== 16'h0000) begin errs++; $display("FAIL recleared_data: got %h, expected 0000", rd_data_q[0]); end
        end
    endtask

`ifdef MBIST_FAULT_INJ_EN
    task automatic test_fault_inj();
        int c0;
        fi_en = 1'b1; fi_addr = 4'd2; fi_bit = 4'd0; fi_val = 1'b1;
        drive(1'b1, 1'b0, 4'd2, 16'h0000, 2'b11);
        drive(1'b1, 1'b0, 4'd3, 16'h0000, 2'b11);
        rd_data_q.delete(); rd_cyc_q.delete();
        drive(1'b0, 1'b1, 4'd2, 16'h0000, 2'b00);
        c0 = cyc;
        drive(1'b0, 1'b1, 4'd3, 16'h0000, 2'b00);
        idle(RD_LAT + 2);
        fi_en = 1'b0;
        drive(1'b0, 1'b1, 4'd2, 16'h0000, 2'b00);
        idle(RD_LAT + 2);
        vecs++;
        if (rd_data_q.size() !== 3) begin
            errs++; $display("FAIL fi_reads: got %0d, expected 3", rd_data_q.size());
        end else begin
            vecs++; if (rd_data_q[0] !== 16'h0001) begin errs++; $display("FAIL fi_forced: got %h, expected 0001", rd_data_q[0]); end
            vecs++; if (rd_cyc_q[0] !== c0 + RD_LAT) begin errs++; $display("FAIL fi_latency: got %0d, expected %0d", rd_cyc_q[0], c0 + RD_LAT); end
            vecs++; if (rd_data_q[1] !== 16'h0000) begin errs++; $display("FAIL fi_other_addr: got %h, expected 0000", rd_data_q[1]); end
            vecs++; if (rd_data_q[2] !== 16'h0000) begin errs++; $display("FAIL fi_disabled: got %h, expected 0000", rd_data_q[2]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clear_readback();
        test_byte_write();
        test_back_to_back();
        test_conflict();
        test_inflight();
        test_reset_mid();
`ifdef MBIST_FAULT_INJ_EN
        test_fault_inj();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
